// File: rtl/eeprom_word_loader.sv
// eeprom_word_loader
//   Boot-time sequencer that sits in front of the `eeprom` byte reader. On
//   start it reads 2*word_count consecutive EEPROM bytes through the
//   reader's strobe/ready handshake. It packs each byte pair (high byte
//   first) into a 16-bit AGC word. Each word is written through a
//   single-cycle memory write port.
//
//   Handshake: eeprom_strobe is a one-cycle request issued only while the
//   reader reports ready. A read completes when ready is seen low and then
//   high again. Ready is still high on the first edge after the strobe, so
//   that stale level is never taken as completion.
//
//   Optional feature (macro PARITY_CHECK_EN): an odd-parity check on each
//   written word. When it is enabled, parity_error is sticky until the next
//   accepted start. When it is disabled, parity_error is tied low.
//
// Ports
//   raw_clk, reset_n    clock, asynchronous active-low reset
//   start               load request (sampled only in IDLE)
//   eeprom_base         first EEPROM byte address
//   mem_base            first destination word address
//   word_count          number of words to load (0 = nothing to do)
//   eeprom_address/_strobe/_ready/_data   byte reader interface
//   mem_address/_data/_write_enable       destination write port
//   busy, done, parity_error              status
//   dbg_state_o         current FSM state (debug observation)
module eeprom_word_loader #(
    parameter int EEPROM_ADDR_WIDTH = 11,
    parameter int MEM_ADDR_WIDTH    = 12,
    parameter int COUNT_WIDTH       = 10
) (
    input  logic                         raw_clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [EEPROM_ADDR_WIDTH-1:0] eeprom_base,
    input  logic [MEM_ADDR_WIDTH-1:0]    mem_base,
    input  logic [COUNT_WIDTH-1:0]       word_count,
    output logic [EEPROM_ADDR_WIDTH-1:0] eeprom_address,
    output logic                         eeprom_strobe,
    input  logic                         eeprom_ready,
    input  logic [7:0]                   eeprom_data,
    output logic [MEM_ADDR_WIDTH-1:0]    mem_address,
    output logic [15:0]                  mem_data,
    output logic                         mem_write_enable,
    output logic                         busy,
    output logic                         done,
    output logic                         parity_error,
    output logic [2:0]                   dbg_state_o
);

    typedef enum logic [2:0] {
        S_SYNC      = 3'd0,
        S_IDLE      = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DATA = 3'd4,
        S_WRITE     = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    state_t                       state_q, state_d;
    logic [EEPROM_ADDR_WIDTH-1:0] byte_addr_q, byte_addr_d;
    logic [MEM_ADDR_WIDTH-1:0]    word_addr_q, word_addr_d;
    logic [COUNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic [7:0]                   hi_q, hi_d;
    logic [7:0]                   lo_q, lo_d;
    logic                         byte_sel_q, byte_sel_d;   // 0 = high byte next, 1 = low byte next
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         start_accept;

    assign start_accept = (state_q == S_IDLE) && start;

    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_SYNC;
            byte_addr_q <= '0;
            word_addr_q <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            byte_sel_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_addr_q <= byte_addr_d;
            word_addr_q <= word_addr_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            byte_sel_q  <= byte_sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_addr_d = byte_addr_q;
        word_addr_d = word_addr_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        byte_sel_d  = byte_sel_q;
        busy_d      = busy_q;
        done_d      = done_q;

        case (state_q)
            // The reader has no reset and may be mid-transfer. Wait until it
            // is idle before any request.
            S_SYNC: begin
                if (eeprom_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (start_accept) begin
                    byte_addr_d = eeprom_base;
                    word_addr_d = mem_base;
                    cnt_d       = word_count;
                    byte_sel_d  = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    state_d     = (word_count == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
            end
            // Ready is still high right after the strobe. Only a low level
            // proves the reader took the request.
            S_WAIT_BUSY: begin
                if (!eeprom_ready) begin
                    state_d = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (eeprom_ready) begin
                    byte_addr_d = byte_addr_q + EEPROM_ADDR_WIDTH'(1);
                    if (!byte_sel_q) begin
                        hi_d       = eeprom_data;
                        byte_sel_d = 1'b1;
                        state_d    = S_ISSUE;
                    end else begin
                        lo_d    = eeprom_data;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_addr_d = word_addr_q + MEM_ADDR_WIDTH'(1);
                cnt_d       = cnt_q - COUNT_WIDTH'(1);
                if (cnt_q == COUNT_WIDTH'(1)) begin
                    state_d = S_FINISH;
                end else begin
                    byte_sel_d = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase
    end

    assign eeprom_address   = byte_addr_q;
    assign eeprom_strobe    = (state_q == S_ISSUE);
    assign mem_address      = word_addr_q;
    assign mem_data         = {hi_q, lo_q};
    assign mem_write_enable = (state_q == S_WRITE);
    assign busy             = busy_q;
    assign done             = done_q;
    assign dbg_state_o      = state_q;

`ifdef PARITY_CHECK_EN
    // AGC words carry odd parity across all 16 bits. An even XOR flags a
    // corrupt word. The word is still written unchanged.
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (start_accept) begin
            parity_d = 1'b0;
        end else if ((state_q == S_WRITE) && !(^{hi_q, lo_q})) begin
            parity_d = 1'b1;
        end
    end

    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_error = parity_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_eeprom_word_loader.sv
module tb_eeprom_word_loader;

  localparam int EAW = 11;
  localparam int MAW = 12;
  localparam int CW  = 10;
`ifdef PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic raw_clk = 1'b0;
  always #5 raw_clk = ~raw_clk;

  logic           reset_n;
  logic           start;
  logic [EAW-1:0] eeprom_base;
  logic [MAW-1:0] mem_base;
  logic [CW-1:0]  word_count;
  logic [EAW-1:0] eeprom_address;
  logic           eeprom_strobe;
  logic           eeprom_ready = 1'b0;
  logic [7:0]     eeprom_data  = 8'h00;
  logic [MAW-1:0] mem_address;
  logic [15:0]    mem_data;
  logic           mem_write_enable;
  logic           busy;
  logic           done;
  logic           parity_error;
  logic [2:0]     dbg_state;

  eeprom_word_loader #(
    .EEPROM_ADDR_WIDTH(EAW),
    .MEM_ADDR_WIDTH(MAW),
    .COUNT_WIDTH(CW)
  ) dut (
    .raw_clk(raw_clk),
    .reset_n(reset_n),
    .start(start),
    .eeprom_base(eeprom_base),
    .mem_base(mem_base),
    .word_count(word_count),
    .eeprom_address(eeprom_address),
    .eeprom_strobe(eeprom_strobe),
    .eeprom_ready(eeprom_ready),
    .eeprom_data(eeprom_data),
    .mem_address(mem_address),
    .mem_data(mem_data),
    .mem_write_enable(mem_write_enable),
    .busy(busy),
    .done(done),
    .parity_error(parity_error),
    .dbg_state_o(dbg_state)
  );

  // ---------------- eeprom behavioural model ----------------
  // Ready stays high for 1..3 edges after a strobe and then drops. It
  // returns high 1..4 edges later with the byte. Garbage data is shown
  // while the read is in flight.
  logic [7:0]     emem [0:2047];
  logic           hold_low;
  int             m_phase = 0;
  int             m_pre   = 0;
  int             m_busy  = 0;
  logic [EAW-1:0] m_addr  = '0;
  int             strobe_err = 0;
  logic [EAW-1:0] strobe_q[$];
  logic [27:0]    wr_q[$];

  always @(negedge raw_clk) begin
    if (eeprom_strobe) begin
      if (hold_low || m_phase != 0 || !eeprom_ready) strobe_err++;
      strobe_q.push_back(eeprom_address);
    end
    if (hold_low) begin
      eeprom_ready = 1'b0;
      m_phase = 0;
    end else begin
      case (m_phase)
        0: begin
          eeprom_ready = 1'b1;
          if (eeprom_strobe) begin
            m_addr  = eeprom_address;
            m_pre   = $urandom_range(1, 3);
            m_busy  = $urandom_range(1, 4);
            m_phase = 1;
          end
        end
        1: begin
          m_pre--;
          if (m_pre == 0) begin
            eeprom_ready = 1'b0;
            eeprom_data  = 8'($urandom);
            m_phase = 2;
          end
        end
        default: begin
          m_busy--;
          if (m_busy == 0) begin
            eeprom_data  = emem[m_addr];
            eeprom_ready = 1'b1;
            m_phase = 0;
          end
        end
      endcase
    end
  end

  // Write-port monitor: {address, data} for each write pulse.
  always @(negedge raw_clk) begin
    if (mem_write_enable) wr_q.push_back({mem_address, mem_data});
  end

  // ---------------- scoreboard ----------------
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [27:0] exp_q[$];
  logic        exp_par;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge raw_clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"},   32'(eeprom_address), 0);
    check({tag, "_strobe"}, 32'(eeprom_strobe), 0);
    check({tag, "_maddr"},  32'(mem_address), 0);
    check({tag, "_mdata"},  32'(mem_data), 0);
    check({tag, "_we"},     32'(mem_write_enable), 0);
    check({tag, "_busy"},   32'(busy), 0);
    check({tag, "_done"},   32'(done), 0);
    check({tag, "_parity"}, 32'(parity_error), 0);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int c = 0;
    while (!done && c < budget) begin
      step();
      c++;
    end
    check({tag, "_done"}, 32'(done), 1);
  endtask

  // Reference: word i comes from bytes base+2i (high) and base+2i+1 (low),
  // goes to mbase+i, and both addresses wrap at their widths.
  task automatic build_expected(input logic [EAW-1:0] base, input logic [MAW-1:0] mbase, input int cnt);
    logic [EAW-1:0] a;
    logic [EAW-1:0] b;
    logic [MAW-1:0] m;
    logic [15:0]    w;
    exp_q.delete();
    exp_par = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      a = base + EAW'(2 * i);
      b = a + EAW'(1);
      m = mbase + MAW'(i);
      w = {emem[a], emem[b]};
      exp_q.push_back({m, w});
      if (PAR_EN && ($countones(w) % 2 == 0)) exp_par = 1'b1;
    end
  endtask

  task automatic run_load(input logic [EAW-1:0] base, input logic [MAW-1:0] mbase, input int cnt, input string tag);
    int s0;
    int w0;
    logic [EAW-1:0] ea;
    s0 = strobe_q.size();
    w0 = wr_q.size();
    build_expected(base, mbase, cnt);
    eeprom_base = base;
    mem_base    = mbase;
    word_count  = CW'(cnt);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_set"}, 32'(busy), 1);
    check({tag, "_done_clr"}, 32'(done), 0);
    wait_done(40 * cnt + 20, tag);
    check({tag, "_busy_end"}, 32'(busy), 0);
    check({tag, "_nstrobe"}, 32'(strobe_q.size() - s0), 32'(2 * cnt));
    for (int i = 0; i < 2 * cnt; i++) begin
      ea = base + EAW'(i);
      if (s0 + i < strobe_q.size()) check({tag, "_saddr"}, 32'(strobe_q[s0 + i]), 32'(ea));
    end
    check({tag, "_nwrite"}, 32'(wr_q.size() - w0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (w0 + i < wr_q.size()) check({tag, "_write"}, 32'(wr_q[w0 + i]), 32'(exp_q[i]));
    end
    check({tag, "_parity"}, 32'(parity_error), 32'(exp_par));
    check({tag, "_protocol"}, 32'(strobe_err), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    int w0;
    int n_before;
    int c;
    reset_n = 1'b0;
    start = 1'b0;
    eeprom_base = '0;
    mem_base = '0;
    word_count = '0;
    hold_low = 1'b1;
    for (int i = 0; i < 2048; i++) emem[i] = 8'($urandom);

    // Reset, then release while the reader reports busy for 50 cycles.
    repeat (3) step();
    check_zero("reset");
    reset_n = 1'b1;
    repeat (20) step();
    eeprom_base = 11'h055;
    word_count = 10'd3;
    start = 1'b1;          // arrives in SYNC: must be dropped
    step();
    start = 1'b0;
    repeat (29) step();
    check("sync_no_strobe", 32'(strobe_q.size()), 0);
    check("sync_busy", 32'(busy), 0);
    hold_low = 1'b0;
    repeat (4) step();
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
    check("idle_no_strobe", 32'(strobe_q.size()), 0);

    // Directed two-word load.
    emem[11'h010] = 8'h12;
    emem[11'h011] = 8'h34;
    emem[11'h012] = 8'hAB;
    emem[11'h013] = 8'hCD;
    w0 = wr_q.size();
    run_load(11'h010, 12'h800, 2, "dir2");
    if (w0 + 1 < wr_q.size()) begin
      check("dir2_w0", 32'(wr_q[w0]), 32'({12'h800, 16'h1234}));
      check("dir2_w1", 32'(wr_q[w0 + 1]), 32'({12'h801, 16'hABCD}));
    end

    // Zero count: no traffic, done within 3 cycles.
    s0 = strobe_q.size();
    w0 = wr_q.size();
    word_count = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(3, "zero");
    check("zero_nstrobe", 32'(strobe_q.size() - s0), 0);
    check("zero_nwrite", 32'(wr_q.size() - w0), 0);
    check("zero_busy", 32'(busy), 0);

    // Address wrap at the top of both spaces.
    run_load(11'h7FF, 12'hABC, 1, "wrap1");
    run_load(11'h7FE, 12'hFFF, 2, "wrap2");

    // Randomized loads against the reference.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 2048; i++) emem[i] = 8'($urandom);
      run_load(EAW'($urandom), MAW'($urandom), $urandom_range(1, 8), "rand");
    end

    // Parity: 0x0001 is odd (good), 0x0003 is even (error).
    emem[11'h200] = 8'h00;
    emem[11'h201] = 8'h01;
    emem[11'h202] = 8'h00;
    emem[11'h203] = 8'h03;
    w0 = wr_q.size();
    eeprom_base = 11'h200;
    mem_base = 12'h100;
    word_count = 10'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    check("par_cleared_by_start", 32'(parity_error), 0);
    c = 0;
    while (wr_q.size() < w0 + 1 && c < 100) begin
      step();
      c++;
    end
    check("par_first_write_seen", 32'(wr_q.size() >= w0 + 1), 1);
    step();
    check("par_after_word0", 32'(parity_error), 0);
    wait_done(100, "par");
    check("par_after_word1", 32'(parity_error), 32'(PAR_EN));
    repeat (5) step();
    check("par_sticky", 32'(parity_error), 32'(PAR_EN));
    word_count = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("par_cleared", 32'(parity_error), 0);
    wait_done(3, "par_zero");

    // Second start mid-load is ignored; then reset aborts the load.
    for (int i = 0; i < 2048; i++) emem[i] = 8'($urandom);
    build_expected(11'h100, 12'h020, 4);
    s0 = strobe_q.size();
    w0 = wr_q.size();
    eeprom_base = 11'h100;
    mem_base = 12'h020;
    word_count = 10'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    c = 0;
    while (wr_q.size() < w0 + 1 && c < 100) begin
      step();
      c++;
    end
    eeprom_base = 11'h300;
    mem_base = 12'h555;
    word_count = 10'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    c = 0;
    while (wr_q.size() < w0 + 2 && c < 100) begin
      step();
      c++;
    end
    check("mid_nwrite", 32'(wr_q.size() - w0), 2);
    for (int i = 0; i < 2; i++) begin
      if (w0 + i < wr_q.size()) check("mid_write", 32'(wr_q[w0 + i]), 32'(exp_q[i]));
    end
    check("mid_busy", 32'(busy), 1);
    repeat (3) step();
    reset_n = 1'b0;
    hold_low = 1'b1;
    #1;
    check_zero("midrst");
    n_before = wr_q.size();
    repeat (3) step();
    reset_n = 1'b1;
    repeat (20) step();
    hold_low = 1'b0;
    repeat (20) step();
    check("midrst_no_write", 32'(wr_q.size()), 32'(n_before));
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_protocol", 32'(strobe_err), 0);
    for (int i = 0; i < strobe_q.size() - s0; i++) begin
      if (i < 8) check("mid_saddr", 32'(strobe_q[s0 + i]), 32'(11'h100 + 11'(i)));
    end

    // A fresh load works after the abort.
    run_load(11'h3F0, 12'h7F0, 3, "post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eeprom_word_loader.md
Name: eeprom_word_loader

Overview:
- Boot-time sequencer placed directly upstream of the `eeprom` byte reader.
- On `start`, it walks a range of EEPROM byte addresses using the reader's strobe/ready handshake.
- It packs byte pairs (high byte first) into 16-bit AGC words (15 data bits plus 1 parity bit) and writes each word into core/fixed memory through a single-cycle write port.
- It signals `done` when the block is complete.

Parameters:
- EEPROM_ADDR_WIDTH, 11, EEPROM byte address width; must match the `eeprom` module's address port.
- MEM_ADDR_WIDTH, 12, word address width of the destination memory.
- COUNT_WIDTH, 10, width of the word-count input.

Ports:
- raw_clk  input  1  system clock, 12 MHz; same clock as `eeprom`.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle load request; sampled only in IDLE.
- eeprom_base  input  EEPROM_ADDR_WIDTH  first EEPROM byte address.
- mem_base  input  MEM_ADDR_WIDTH  first destination word address.
- word_count  input  COUNT_WIDTH  number of 16-bit words to load.
- eeprom_address  output  EEPROM_ADDR_WIDTH  byte address presented to `eeprom`.
- eeprom_strobe  output  1  read request to `eeprom`.
- eeprom_ready  input  1  ready from `eeprom`: 1 = idle / data valid.
- eeprom_data  input  8  data_out from `eeprom`.
- mem_address  output  MEM_ADDR_WIDTH  word write address.
- mem_data  output  16  assembled word: `{hi_byte, lo_byte}`.
- mem_write_enable  output  1  single-cycle write pulse.
- busy  output  1  high from accepted start until done.
- done  output  1  level; set when load completes, cleared by next accepted start.
- parity_error  output  1  sticky parity flag (see Optional Feature).

Behaviour:
- Reset (async, reset_n = 0): all outputs are 0; state = SYNC; internal counters are cleared.
- SYNC: wait for `eeprom_ready` = 1, then go to IDLE. This covers `eeprom` having no reset and possibly being mid-transfer.
- IDLE:
  - On `start` = 1, latch `eeprom_base`, `mem_base` and `word_count`; set `busy` = 1 and `done` = 0.
  - If the latched count = 0, go to FINISH. Otherwise go to ISSUE with byte_sel = HI.
- ISSUE: drive `eeprom_address` = current byte address and `eeprom_strobe` = 1 for exactly one cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait until `eeprom_ready` = 0, then go to WAIT_DATA.
  - Mandatory: `ready` is still 1 on the first edge after the strobe, so a stale ready must never be taken as a completion.
- WAIT_DATA:
  - On `eeprom_ready` = 1, capture `eeprom_data` into the hi or lo byte register and increment the byte address (wraps modulo 2^EEPROM_ADDR_WIDTH).
  - If byte_sel = HI: set byte_sel = LO and go to ISSUE. Otherwise go to WRITE.
- WRITE:
  - `mem_write_enable` = 1 for one cycle, with `mem_address`/`mem_data` valid in the same cycle.
  - Increment the word address (wraps modulo 2^MEM_ADDR_WIDTH) and decrement the remaining count.
  - If the remaining count is now 0, go to FINISH. Otherwise set byte_sel = HI and go to ISSUE.
- FINISH: `busy` = 0, `done` = 1; go to IDLE.
- `eeprom_strobe` is never high outside ISSUE. `eeprom_address` holds its value from ISSUE through WAIT_DATA.
- `start` while `busy`: ignored.
- `start` in SYNC: ignored (no queuing).
- Maximum count: 2^COUNT_WIDTH − 1 words; the count is never interpreted as 2^COUNT_WIDTH.
- Reset mid-load:
  - Immediate abort; no further writes.
  - Re-enter SYNC, then wait for `eeprom` to return ready before any new strobe.
- Throughput: one word per two EEPROM reads, plus 1 WRITE cycle and 2 ISSUE/handshake cycles per byte.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - In WRITE, compute the XOR of all 16 bits of the word; the AGC uses odd parity, so the XOR must be 1.
  - If the XOR is 0, set `parity_error` = 1. It is sticky until the next accepted start.
  - The word is still written unchanged.
- Undefined: `parity_error` is tied to 0 and no parity logic is synthesized.

Test Plan:
- Reset release with the `eeprom` model reporting ready = 0 for 50 cycles -> no strobe until ready = 1; the block then reaches IDLE with busy = 0 and done = 0.
- start with eeprom_base = 0x010, mem_base = 0x800, word_count = 2, and model bytes 0x12, 0x34, 0xAB, 0xCD -> exactly 4 strobes at addresses 0x010–0x013; writes of 0x1234 @ 0x800 and 0xABCD @ 0x801; then done = 1 and busy = 0.
- word_count = 0 -> no strobe, no write; done = 1 within 3 cycles of start.
- eeprom_base = 0x7FF, word_count = 1 -> strobes at 0x7FF then 0x000 (wrap); a single write follows.
- start pulsed again mid-load, then reset_n pulsed low mid-load -> the second start is ignored; after reset, all outputs are 0 and no write occurs until a new start after SYNC.
- PARITY_CHECK_EN defined:
  - Words 0x0001 and 0x0003 -> parity_error stays 0 after the first word and becomes 1 after the second.
  - parity_error stays set until the next start, which clears it.
